// File: rtl/pipe_pkg.sv
// Shared definitions for the multi-lane pipeline stage: occupancy states,
// stall counter limits and the lane-slice helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int unsigned   STALL_W   = 16;
  localparam logic [15:0]   STALL_MAX = 16'hFFFF;

  // Lowest bit index of a lane inside a packed bundle payload.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/lane_squash.sv
// Per-lane squash mask: kills the requested lanes and, optionally, every
// younger lane above the oldest killed one.
module lane_squash #(
  parameter int LANES          = 2,
  parameter int SQUASH_YOUNGER = 1
) (
  input  logic [LANES-1:0] in_lane,
  input  logic [LANES-1:0] kill_mask,
  output logic [LANES-1:0] eff_mask
);

  logic seen_kill_s;

  // Walk lanes oldest to youngest, remembering whether an older lane was killed.
  always_comb begin
    eff_mask    = {LANES{1'b0}};
    seen_kill_s = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if ((SQUASH_YOUNGER != 0) && seen_kill_s) begin
        eff_mask[k] = 1'b0;
      end else begin
        eff_mask[k] = in_lane[k] & ~kill_mask[k];
      end
      seen_kill_s = seen_kill_s | kill_mask[k];
    end
  end

endmodule

// File: rtl/multi_lane_stage.sv
// Two-entry (main + skid) multi-lane pipeline register with squash, hold,
// flush and a saturating back-pressure counter.
module multi_lane_stage
  import pipe_pkg::*;
#(
  parameter int LANES          = 2,
  parameter int WIDTH          = 52,
  parameter int SQUASH_YOUNGER = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES-1:0]       in_lane,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       kill_mask,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [LANES-1:0]       out_lane,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic                   out_ready,
  input  logic                   hold,
  input  logic                   flush,
  output logic [15:0]            stall_cnt
);

  localparam int BW = LANES * WIDTH;

  stage_state_e     state_r;
  logic [LANES-1:0] main_lane_r;
  logic [LANES-1:0] skid_lane_r;
  logic [BW-1:0]    main_data_r;
  logic [BW-1:0]    skid_data_r;
  logic [15:0]      stall_r;

  logic [LANES-1:0] eff_mask_s;
  logic             out_valid_s;
  logic             store_s;
  logic             pop_s;

  lane_squash #(
    .LANES          (LANES),
    .SQUASH_YOUNGER (SQUASH_YOUNGER)
  ) u_lane_squash (
    .in_lane   (in_lane),
    .kill_mask (kill_mask),
    .eff_mask  (eff_mask_s)
  );

  // Ready depends only on registered occupancy, never on out_ready.
  assign out_valid_s = (state_r != ST_EMPTY);
  assign in_ready    = !rst && !hold && (state_r != ST_FULL);
  assign store_s     = in_valid && in_ready && !flush && (eff_mask_s != {LANES{1'b0}});
  assign pop_s       = out_valid_s && out_ready && !hold;

  assign out_valid = out_valid_s;
  assign out_lane  = main_lane_r;
  assign out_data  = main_data_r;
  assign stall_cnt = stall_r;

  // Occupancy and bundle storage; flush clears only the occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      main_lane_r <= {LANES{1'b0}};
      skid_lane_r <= {LANES{1'b0}};
      main_data_r <= {BW{1'b0}};
      skid_data_r <= {BW{1'b0}};
    end else if (flush) begin
      state_r <= ST_EMPTY;
    end else if (!hold) begin
      case (state_r)
        ST_EMPTY: begin
          if (store_s) begin
            main_lane_r <= eff_mask_s;
            main_data_r <= in_data;
            state_r     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop_s && store_s) begin
            main_lane_r <= eff_mask_s;
            main_data_r <= in_data;
          end else if (pop_s) begin
            state_r <= ST_EMPTY;
          end else if (store_s) begin
            skid_lane_r <= eff_mask_s;
            skid_data_r <= in_data;
            state_r     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            main_lane_r <= skid_lane_r;
            main_data_r <= skid_data_r;
            state_r     <= ST_ONE;
          end
        end
        default: state_r <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a presented bundle was not consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= 16'd0;
    end else if (out_valid_s && (!out_ready || hold) && (stall_r != STALL_MAX)) begin
      stall_r <= stall_r + 16'd1;
    end
  end

endmodule

// File: doc/multi_lane_stage.md
MULTI_LANE_STAGE -- requirements
Module: multi_lane_stage

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of issue lanes per bundle (1..8).
REQ-002 SHALL have parameter WIDTH, default 52, meaning the payload bits per lane.
REQ-003 SHALL have parameter SQUASH_YOUNGER, default 1, meaning a killed lane also kills all higher-index (younger) lanes.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream bundle is offered.
REQ-007 SHALL have port in_lane, input, LANES bits: per-lane valid mask of the offered bundle.
REQ-008 SHALL have port in_data, input, LANES*WIDTH bits: lane k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port kill_mask, input, LANES bits: lanes of the offered bundle to squash (flush_second generalised).
REQ-010 SHALL have port in_ready, output, 1 bit: the stage accepts the offered bundle this cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: a bundle is presented downstream.
REQ-012 SHALL have port out_lane, output, LANES bits: per-lane valid mask of the presented bundle.
REQ-013 SHALL have port out_data, output, LANES*WIDTH bits: payload of the presented bundle.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream consumes the bundle.
REQ-015 SHALL have port hold, input, 1 bit: freeze the stage (load-use stall); while high it is treated as out_ready=0 and in_ready=0.
REQ-016 SHALL have port flush, input, 1 bit: discard all stored bundles.
REQ-017 SHALL have port stall_cnt, output, 16 bits: saturating count of back-pressured cycles.

Function
REQ-018 SHALL hold up to two bundles (main + skid) with a 2-bit state in EMPTY, ONE or FULL.
REQ-019 SHALL drive in_ready = !hold && (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-020 SHALL compute eff_mask = in_lane & ~kill_mask; with SQUASH_YOUNGER=1 it SHALL also clear every lane above the lowest-index set bit of kill_mask.
REQ-021 SHALL treat a bundle as accepted when in_valid && in_ready; an accepted bundle whose eff_mask is 0 SHALL be dropped and not stored.
REQ-022 SHALL define pop = out_valid && out_ready && !hold.
REQ-023 SHALL present main on out_*; out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY; out_lane SHALL always be non-zero when out_valid=1.
REQ-024 Transitions:
- EMPTY to ONE on store.
- ONE to EMPTY on pop without store.
- ONE to FULL on store without pop; the stored bundle goes to skid.
- ONE stays ONE on pop with store; the new bundle replaces main.
- FULL to ONE on pop; skid moves to main.
REQ-025 Latency SHALL be 1 cycle: a bundle accepted at edge N appears on out_* after edge N when the stage was EMPTY or popped at N.
REQ-026 SHALL preserve strict bundle order; lane order within a bundle is never permuted.
REQ-027 On flush, the stage SHALL go to EMPTY at the next edge, and a bundle offered in the same cycle SHALL be dropped; flush overrides hold.
REQ-028 While hold=1 and flush=0, state and storage SHALL be unchanged.
REQ-029 stall_cnt SHALL increment when out_valid && (!out_ready || hold), saturate at 16'hFFFF, and never wrap.
REQ-030 Data registers SHALL NOT be cleared by flush; only valid state is cleared.

Reset
REQ-031 On rst high, the stage SHALL immediately be in EMPTY, with out_valid=0, out_lane=0, out_data=0, stall_cnt=0 and in_ready=0 while rst is asserted.
REQ-032 Reset mid-operation SHALL discard both stored bundles, with no partial output after release.

Structure
REQ-033 State encodings (EMPTY/ONE/FULL) and the lane-slice helper SHALL live in a shared package, pipe_pkg.
REQ-034 Squash-mask generation SHALL be one sub-module, lane_squash (combinational, parametrised by LANES and SQUASH_YOUNGER).
REQ-035 The block SHALL replace fixed-width IFID/IDEX instances in the dual-issue top without changing their flush/hold meaning.

Verification (LANES=2, WIDTH=8)
REQ-036 Scenario, pass-through: offer A (lane 11, data 0x22_11) with out_ready=1 -> out A after 1 cycle, in_ready stays 1.
REQ-037 Scenario, back-pressure: offer A, B and C with out_ready=0 -> FULL after B, in_ready=0, C held; raise out_ready -> A, B, C out in order; stall_cnt=2.
REQ-038 Scenario, squash: offer in_lane=11 with kill_mask=01 and SQUASH_YOUNGER=1 -> bundle dropped, out_valid stays 0; with SQUASH_YOUNGER=0 -> out_lane=10.
REQ-039 Scenario, flush while FULL with a concurrent offer -> EMPTY next cycle, out_valid=0, offered bundle lost.
REQ-040 Scenario, hold: hold=1 for 3 cycles while ONE -> out_data stable, in_ready=0, stall_cnt increases by 3.
REQ-041 Scenario, reset: assert rst asynchronously between edges while FULL -> out_valid=0 immediately; stall_cnt forced to 0xFFFF before reset reads 0 after.
